// File: rtl/issue_scoreboard.sv
// Decode-stage scoreboard for long-latency writers: per-register busy bits, RAW/WAW stall,
// fence/CSR drain sequencing and a writeback watchdog.
module issue_scoreboard #(
    parameter int NREG      = 32,
    parameter int WD_CYCLES = 1024,
    parameter int CNT_W     = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_D,
    input  logic             ready_E,
    input  logic [4:0]       rs1_D,
    input  logic [4:0]       rs2_D,
    input  logic             use_rs1_D,
    input  logic             use_rs2_D,
    input  logic [4:0]       rd_D,
    input  logic             long_D,
    input  logic             wb_long,
    input  logic [4:0]       wb_rd,
    input  logic             drain_req,
    output logic             stall_D,
    output logic             issue_fire,
    output logic             drain_done,
    output logic [CNT_W-1:0] outstanding,
    output logic             err_hang
);

    localparam int WD_W = $clog2(WD_CYCLES + 1);

    typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

    state_t            state;
    logic [NREG-1:0]   busy;
    logic [WD_W-1:0]   wd_cnt;
    logic [WD_W-1:0]   wd_next;
    logic [CNT_W-1:0]  out_next;
    logic              raw;
    logic              waw;
    logic              set_busy;
    logic              clr_busy;

    always_comb begin
        raw        = (use_rs1_D & busy[rs1_D]) | (use_rs2_D & busy[rs2_D]);
        waw        = long_D & busy[rd_D];
        stall_D    = valid_D & (raw | waw | (state != RUN));
        issue_fire = valid_D & ~stall_D & ready_E;
        set_busy   = issue_fire & long_D & (rd_D != 5'd0);
        // Writebacks to idle registers are dropped so the counter tracks busy[] exactly.
        clr_busy   = wb_long & (wb_rd != 5'd0) & busy[wb_rd];
        out_next   = outstanding + CNT_W'(set_busy) - CNT_W'(clr_busy);
        wd_next    = wd_cnt;
        if ((outstanding == '0) || clr_busy)
            wd_next = '0;
        else if (wd_cnt != WD_W'(WD_CYCLES))
            wd_next = wd_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy        <= '0;
            outstanding <= '0;
            state       <= RUN;
            drain_done  <= 1'b0;
            err_hang    <= 1'b0;
            wd_cnt      <= '0;
        end else begin
            if (set_busy)
                busy[rd_D] <= 1'b1;
            if (clr_busy)
                busy[wb_rd] <= 1'b0;
            outstanding <= out_next;
            wd_cnt      <= wd_next;
            if (wd_next == WD_W'(WD_CYCLES))
                err_hang <= 1'b1;
            drain_done <= 1'b0;
            case (state)
                RUN: begin
                    if (drain_req)
                        state <= DRAIN;
                end
                DRAIN: begin
                    // Look at the post-update count so a final clear finishes the drain this cycle.
                    if (out_next == '0) begin
                        state      <= DONE;
                        drain_done <= 1'b1;
                    end
                end
                DONE: begin
                    state <= RUN;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_issue_scoreboard.sv
// Self-checking bench for issue_scoreboard: directed scenarios then randomized traffic,
// all compared against a register-set reference model.
module tb_issue_scoreboard;

    localparam int WD = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       valid_D, ready_E, use_rs1_D, use_rs2_D, long_D, wb_long, drain_req;
    logic [4:0] rs1_D, rs2_D, rd_D, wb_rd;
    logic       stall_D, issue_fire, drain_done, err_hang;
    logic [5:0] outstanding;

    int checks = 0;
    int errors = 0;

    // reference model state
    bit [31:0] mbusy;
    bit        m_drain, m_done, m_err;
    int        m_age;

    issue_scoreboard #(.NREG(32), .WD_CYCLES(WD), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .valid_D(valid_D), .ready_E(ready_E),
        .rs1_D(rs1_D), .rs2_D(rs2_D), .use_rs1_D(use_rs1_D), .use_rs2_D(use_rs2_D),
        .rd_D(rd_D), .long_D(long_D), .wb_long(wb_long), .wb_rd(wb_rd),
        .drain_req(drain_req), .stall_D(stall_D), .issue_fire(issue_fire),
        .drain_done(drain_done), .outstanding(outstanding), .err_hang(err_hang)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        valid_D = 0; ready_E = 1; use_rs1_D = 0; use_rs2_D = 0; long_D = 0;
        wb_long = 0; drain_req = 0; rs1_D = 0; rs2_D = 0; rd_D = 0; wb_rd = 0;
    endtask

    task automatic instr(input logic [4:0] rd, input bit lng, input logic [4:0] r1, input bit u1,
                         input logic [4:0] r2, input bit u2);
        valid_D = 1; ready_E = 1; rd_D = rd; long_D = lng;
        rs1_D = r1; use_rs1_D = u1; rs2_D = r2; use_rs2_D = u2;
    endtask

    task automatic model_reset();
        mbusy = '0; m_drain = 0; m_done = 0; m_err = 0; m_age = 0;
    endtask

    // One clock: compare against the model, take the edge, advance the model.
    task automatic cycle();
        bit raw, waw, e_stall, e_fire, set, clr;
        int m_out;
        #1;
        m_out   = $countones(mbusy);
        raw     = (use_rs1_D && mbusy[rs1_D]) || (use_rs2_D && mbusy[rs2_D]);
        waw     = long_D && mbusy[rd_D];
        e_stall = valid_D && (raw || waw || m_drain || m_done);
        e_fire  = valid_D && !e_stall && ready_E;
        chk("stall_D", stall_D, e_stall);
        chk("issue_fire", issue_fire, e_fire);
        chk("drain_done", drain_done, m_done);
        chk("outstanding", outstanding, m_out);
        chk("err_hang", err_hang, m_err);
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            set = e_fire && long_D && (rd_D != 0);
            clr = wb_long && (wb_rd != 0) && mbusy[wb_rd];
            assert (!(set && clr && rd_D == wb_rd)) else begin
                errors++;
                $error("FAIL set_clr_same_reg: observed rd %0d expected distinct from wb_rd", rd_D);
            end
            if (m_out == 0 || clr) m_age = 0;
            else if (m_age < WD) m_age++;
            if (m_age == WD) m_err = 1;
            if (set) mbusy[rd_D] = 1'b1;
            if (clr) mbusy[wb_rd] = 1'b0;
            if (m_done) m_done = 0;
            else if (m_drain) begin
                if ($countones(mbusy) == 0) begin m_drain = 0; m_done = 1; end
            end else if (drain_req) m_drain = 1;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle(); rst = 1;
        cycle();
        rst = 0;
    endtask

    initial begin
        idle(); rst = 1;
        repeat (2) @(posedge clk);
        model_reset();
        @(negedge clk);
        rst = 0;
        #1;
        chk("reset_outstanding", outstanding, 0);
        chk("reset_err_hang", err_hang, 0);
        chk("reset_drain_done", drain_done, 0);

        // load x5 long, then add x6,x5,x1
        instr(5, 1, 0, 0, 0, 0); #1; chk("load_fire", issue_fire, 1); cycle();
        instr(6, 0, 5, 1, 1, 1); #1; chk("raw_stall_a", stall_D, 1); cycle();
        wb_long = 1; wb_rd = 5;  #1; chk("raw_stall_wb", stall_D, 1); cycle();
        wb_long = 0;             #1; chk("raw_release", issue_fire, 1); cycle();

        // long to x0 then a reader of x0
        instr(0, 1, 0, 0, 0, 0); cycle();
        instr(8, 0, 0, 1, 0, 1); #1; chk("x0_no_stall", stall_D, 0);
        chk("x0_outstanding", outstanding, 0); cycle();

        // WAW against in-flight div x7
        instr(7, 1, 1, 1, 2, 1); cycle();
        instr(7, 1, 2, 1, 3, 0); #1; chk("waw_stall", stall_D, 1); cycle();
        wb_long = 1; wb_rd = 7;  #1; chk("waw_stall_wb", stall_D, 1); cycle();
        wb_long = 0;             #1; chk("waw_fire", issue_fire, 1); cycle();
        idle(); wb_long = 1; wb_rd = 7; cycle();
        idle(); cycle();

        // drain with x3,x4 outstanding
        instr(3, 1, 0, 0, 0, 0); cycle();
        instr(4, 1, 0, 0, 0, 0); cycle();
        idle(); drain_req = 1; #1; chk("drain_out2", outstanding, 2); cycle();
        idle(); repeat (2) cycle();
        wb_long = 1; wb_rd = 3; cycle();
        idle(); repeat (4) cycle();
        wb_long = 1; wb_rd = 4; #1; chk("drain_not_done", drain_done, 0); cycle();
        instr(10, 0, 0, 0, 0, 0); #1; chk("drain_done_pulse", drain_done, 1);
        chk("done_blocks", stall_D, 1); cycle();
        #1; chk("drain_done_clear", drain_done, 0); chk("run_again", issue_fire, 1); cycle();

        // drain with nothing outstanding: pulse two cycles after request
        idle(); drain_req = 1; cycle();
        idle(); #1; chk("drain0_wait", drain_done, 0); cycle();
        #1; chk("drain0_done", drain_done, 1); cycle();

        // watchdog
        do_reset();
        instr(9, 1, 0, 0, 0, 0); cycle();
        idle(); repeat (7) cycle();
        #1; chk("wd_before", err_hang, 0); cycle();
        wb_long = 1; wb_rd = 9; #1; chk("wd_hit", err_hang, 1); cycle();
        idle(); #1; chk("wd_sticky", err_hang, 1); chk("wd_out0", outstanding, 0); cycle();

        // reset during DRAIN with two outstanding
        do_reset();
        instr(3, 1, 0, 0, 0, 0); cycle();
        instr(4, 1, 0, 0, 0, 0); cycle();
        idle(); drain_req = 1; cycle();
        idle(); rst = 1; #1; chk("pre_rst_out", outstanding, 2); cycle();
        rst = 0; instr(11, 0, 3, 1, 0, 0); #1;
        chk("rst_out0", outstanding, 0); chk("rst_no_pulse", drain_done, 0);
        chk("rst_run", issue_fire, 1); cycle();
        idle(); wb_long = 1; wb_rd = 4; cycle();
        idle(); #1; chk("late_wb_ignored", outstanding, 0); cycle();

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            bit [31:0] cand;
            idle();
            valid_D   = ($urandom % 4) != 0;
            ready_E   = ($urandom % 5) != 0;
            rs1_D     = 5'($urandom % 8);
            rs2_D     = 5'($urandom % 8);
            use_rs1_D = $urandom % 2;
            use_rs2_D = $urandom % 2;
            rd_D      = 5'($urandom % 8);
            long_D    = ($urandom % 3) == 0;
            drain_req = ($urandom % 40) == 0;
            rst       = ($urandom % 300) == 0;
            cand      = mbusy;
            if (cand != 0 && ($urandom % 4) == 0) begin
                int pick = $urandom % 32;
                while (!cand[pick]) pick = (pick + 1) % 32;
                wb_long = 1; wb_rd = 5'(pick);
            end else if (($urandom % 16) == 0) begin
                wb_long = 1; wb_rd = 5'($urandom % 32);
            end
            cycle();
            rst = 0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
